// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - bus widths and field offsets of the execute->mem, mem->writeback and
//     mem->decode forwarding buses
//   - load-type codes carried in the execute bus
//   - load FSM state encodings
//   - packed structs overlaying each bus, plus a small extension helper
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    // Bus widths
    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FWD_BUS_WD   = 39;

    // execute -> mem field offsets
    localparam int ES_LD_TYPE_HI   = 73;
    localparam int ES_LD_TYPE_LO   = 71;
    localparam int ES_RES_FROM_MEM = 70;
    localparam int ES_GR_WE        = 69;
    localparam int ES_DEST_HI      = 68;
    localparam int ES_DEST_LO      = 64;
    localparam int ES_ALU_HI       = 63;
    localparam int ES_ALU_LO       = 32;
    localparam int ES_PC_HI        = 31;
    localparam int ES_PC_LO        = 0;

    // mem -> writeback field offsets
    localparam int MS_GR_WE        = 69;
    localparam int MS_DEST_HI      = 68;
    localparam int MS_DEST_LO      = 64;
    localparam int MS_RESULT_HI    = 63;
    localparam int MS_RESULT_LO    = 32;
    localparam int MS_PC_HI        = 31;
    localparam int MS_PC_LO        = 0;

    // mem -> decode forwarding field offsets
    localparam int FWD_VALID       = 38;
    localparam int FWD_LOAD_PEND   = 37;
    localparam int FWD_DEST_HI     = 36;
    localparam int FWD_DEST_LO     = 32;
    localparam int FWD_RESULT_HI   = 31;
    localparam int FWD_RESULT_LO   = 0;

    // Load-type codes; any unlisted code is treated as a full word
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_H  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } ld_type_e;

    // Load FSM states
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_HOLD = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic [2:0]  ld_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        fwd_valid;
        logic        load_pending;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_fwd_t;

    // Extend a 16-bit value to 32 bits; sign bit taken from bit 15
    function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

    // Extend an 8-bit value to 32 bits; sign bit taken from bit 7
    function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load-data alignment. Picks the addressed byte or halfword out
// of the 32-bit SRAM word and sign- or zero-extends it according to ld_type.
// Ports:
//   ld_type      in  3   load-type code (LD_W/LD_B/LD_H/LD_BU/LD_HU)
//   addr         in  2   low address bits of the load
//   rdata        in  32  raw word from the data SRAM (or its hold buffer)
//   load_result  out 32  aligned and extended result
// -----------------------------------------------------------------------------
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] load_result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Halfword selection ignores addr[0]; misalignment is caught upstream.
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_result = rdata;
        case (ld_type_e'(ld_type))
            LD_B:    load_result = ext8(byte_sel, 1'b1);
            LD_BU:   load_result = ext8(byte_sel, 1'b0);
            LD_H:    load_result = ext16(half_sel, 1'b1);
            LD_HU:   load_result = ext16(half_sel, 1'b0);
            default: load_result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between execute and writeback. Latches the
// execute bus, waits for variable-latency load data from the data SRAM,
// aligns/extends sub-word loads and hands the result to writeback. Also drives
// a forwarding/interlock bus back to decode.
// Ports:
//   clk                in  1   clock
//   reset              in  1   asynchronous active-low reset
//   ws_allowin         in  1   writeback can accept this cycle
//   ms_allowin         out 1   this stage can accept this cycle
//   es_to_ms_valid     in  1   execute offers an instruction
//   es_to_ms_bus       in  74  {ld_type, res_from_mem, gr_we, dest, alu_result, pc}
//   data_sram_data_ok  in  1   load data valid this cycle
//   data_sram_rdata    in  32  load data
//   ms_to_ws_valid     out 1   result offered to writeback
//   ms_to_ws_bus       out 70  {gr_we, dest, final_result, pc}
//   ms_fwd_bus         out 39  {fwd_valid, load_pending, dest, final_result}
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    es_to_ms_t  es_in;
    es_to_ms_t  bus_q;
    logic       ms_valid_q;
    ms_state_e  state_q, state_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_ready_go;
    logic        accept;
    logic [31:0] align_src;
    logic [31:0] load_result;
    logic [31:0] final_result;
    ms_to_ws_t   ws_out;
    ms_fwd_t     fwd_out;

    assign es_in = es_to_ms_bus;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // A load is only ready once data has arrived (WAIT + data_ok) or has
    // been parked in the hold buffer (HOLD). Non-loads pass in one cycle.
    always_comb begin
        ms_ready_go = 1'b1;
        if (bus_q.res_from_mem) begin
            case (state_q)
                MS_WAIT: ms_ready_go = data_sram_data_ok;
                MS_HOLD: ms_ready_go = 1'b1;
                default: ms_ready_go = 1'b0;
            endcase
        end
    end

    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    // ------------------------------------------------------------------
    // Load FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;
        case (state_q)
            MS_WAIT: begin
                if (data_sram_data_ok) begin
                    if (ws_allowin) begin
                        state_d = MS_IDLE;
                    end else begin
                        // Writeback is stalled: park the word, since the
                        // SRAM only presents it for this one cycle.
                        state_d     = MS_HOLD;
                        rdata_buf_d = data_sram_rdata;
                    end
                end
            end
            MS_HOLD: begin
                if (ws_allowin) state_d = MS_IDLE;
            end
            default: ;
        endcase
        // A new instruction entering overrides whatever the old one decided.
        if (accept) state_d = es_in.res_from_mem ? MS_WAIT : MS_IDLE;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            state_q     <= MS_IDLE;
            rdata_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
            if (ms_allowin) ms_valid_q <= es_to_ms_valid;
            if (accept)     bus_q      <= es_in;
        end
    end

    // ------------------------------------------------------------------
    // Result path
    // ------------------------------------------------------------------
    assign align_src = (state_q == MS_HOLD) ? rdata_buf_q : data_sram_rdata;

    mem_load_align u_align (
        .ld_type     (bus_q.ld_type),
        .addr        (bus_q.alu_result[1:0]),
        .rdata       (align_src),
        .load_result (load_result)
    );

    assign final_result = bus_q.res_from_mem ? load_result : bus_q.alu_result;

    always_comb begin
        ws_out.gr_we        = bus_q.gr_we;
        ws_out.dest         = bus_q.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = bus_q.pc;
    end

    // Decode must interlock on load_pending: final_result is not yet real.
    always_comb begin
        fwd_out.fwd_valid    = ms_valid_q && bus_q.gr_we && (bus_q.dest != 5'd0);
        fwd_out.load_pending = ms_valid_q && bus_q.res_from_mem && !ms_ready_go;
        fwd_out.dest         = bus_q.dest;
        fwd_out.final_result = final_result;
    end

    assign ms_to_ws_bus = ws_out;
    assign ms_fwd_bus   = fwd_out;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of writeback. It latches the execute-stage bus and waits for load data from the data SRAM, which returns it with a variable-latency data_ok pulse. It aligns and sign- or zero-extends sub-word loads, then passes the final result to writeback. It also exports a forwarding/interlock bus to decode.

Parameters:
- None. All widths come from mycpu.vh.
- ES_TO_MS_BUS_WD: 74.
- MS_TO_WS_BUS_WD: 70.
- MS_FWD_BUS_WD: 39.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (low = reset).
- ws_allowin  in  1  writeback can accept this cycle.
- ms_allowin  out  1  this stage can accept this cycle.
- es_to_ms_valid  in  1  execute offers an instruction.
- es_to_ms_bus  in  74  field layout:
  - [73:71] ld_type
  - [70] res_from_mem
  - [69] gr_we
  - [68:64] dest
  - [63:32] alu_result (this is the load address for loads)
  - [31:0] pc
- data_sram_data_ok  in  1  load data valid this cycle.
- data_sram_rdata  in  32  load data.
- ms_to_ws_valid  out  1  result offered to writeback.
- ms_to_ws_bus  out  70  field layout:
  - [69] gr_we
  - [68:64] dest
  - [63:32] final_result
  - [31:0] pc
- ms_fwd_bus  out  39  field layout:
  - [38] fwd_valid
  - [37] load_pending
  - [36:32] dest
  - [31:0] final_result

Behaviour:
- Reset (async, reset low):
  - ms_valid=0.
  - Bus register=0.
  - state=IDLE.
  - rdata_buf=0.
  - Therefore ms_to_ws_valid=0, ms_allowin=1 and ms_fwd_bus=0 while in reset.
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - When ms_allowin is high: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: bus register <= es_to_ms_bus.
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Non-load (res_from_mem=0):
  - ms_ready_go=1, so latency is 1 cycle through the stage.
  - final_result = alu_result.
- Load FSM, states IDLE / WAIT / HOLD:
  - Accept of a load (res_from_mem=1): next state = WAIT, from any state.
  - Accept of a non-load: next state = IDLE.
  - WAIT with data_ok=1: result comes from live rdata and ms_ready_go=1.
    - If ws_allowin is also high: leave WAIT (next state set by any same-cycle accept, else IDLE).
    - If ws_allowin is low: rdata_buf <= rdata and go to HOLD.
  - WAIT with data_ok=0: ms_ready_go=0 and the stage stalls.
  - HOLD: ms_ready_go=1 and the result comes from rdata_buf. rdata_buf is stable regardless of the live rdata bus. Leave HOLD when ws_allowin is high.
  - data_ok may arrive in the first cycle the load is valid in this stage (synchronous 1-cycle SRAM case).
  - data_ok in IDLE or HOLD is ignored and causes no state change.
- Load alignment (src = live rdata or rdata_buf; a = alu_result[1:0]):
  - ld_type 0, ld.w: src.
  - ld_type 1, ld.b: src byte a, sign-extended.
  - ld_type 3, ld.bu: src byte a, zero-extended.
  - ld_type 2, ld.h: halfword a[1], sign-extended.
  - ld_type 4, ld.hu: halfword a[1], zero-extended.
  - Codes 5–7 behave as ld.w.
  - Misalignment is not checked here (execute owns it). For halfwords a[0] is ignored.
- Forwarding:
  - fwd_valid = ms_valid && gr_we && dest != 0.
  - load_pending = ms_valid && res_from_mem && !ms_ready_go. Decode must stall when load_pending is high and its source matches dest.
- ms_to_ws_bus and ms_fwd_bus are combinational from the stage registers and the FSM.

Decomposition:
- mycpu.vh holds:
  - the three bus widths and every field offset above;
  - LD_W/LD_B/LD_H/LD_BU/LD_HU codes 0,2,1... specifically LD_W=0, LD_B=1, LD_H=2, LD_BU=3, LD_HU=4;
  - the state encodings MS_IDLE=0, MS_WAIT=1, MS_HOLD=2.
- One combinational sub-module, mem_load_align: inputs ld_type, addr[1:0], rdata[31:0]; output load_result[31:0].

Test Plan:
- ALU pass-through: non-load with alu_result=0x12345678, gr_we=1, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x12345678, dest=5, ms_allowin stays 1.
- Alignment: rdata=0x1280FF34 with immediate data_ok ->
  - ld.b a=1 -> 0xFFFFFFFF
  - ld.bu a=2 -> 0x00000080
  - ld.h a=2 -> 0x00001280
  - ld.h a=0 -> 0xFFFFFF34
  - ld.hu a=0 -> 0x0000FF34
  - ld.w -> 0x1280FF34
- Delayed data: data_ok 3 cycles after the load enters -> ms_to_ws_valid=0, ms_allowin=0, load_pending=1 for 3 cycles; on the data_ok cycle, valid=1 and pending=0.
- Writeback stall: data_ok with rdata=0xAABBCCDD while ws_allowin=0 for 2 cycles, rdata then driven to 0xDEADBEEF -> state HOLD; final_result stays 0xAABBCCDD until ws_allowin=1, then retires once.
- Back-to-back: 4 consecutive ld.w with data_ok and ws_allowin held high -> one retirement per cycle, pcs in order, no bubbles.
- Reset mid-load: pull reset low while in WAIT -> ms_valid=0 immediately (before the next clk edge); after release, a stray data_ok produces no ms_to_ws_valid.
